alu_subunit_router: RTL and testbench
=====================================

# alu_subunit_router

Parametrised request router and response merger for one ALU block. It steers each dispatched ALU request to one of `NUM_UNITS` functional sub-units (integer, mul/div, and future units) by a unit-select field, and merges their commit responses round-robin into one buffered commit stream. It also limits the number of in-flight requests per warp and supports a drain mode for pipeline quiescence. It sits between the per-block dispatch output and the per-block commit input of the ALU unit, once per block.

## Interface
Parameters:
- `NUM_UNITS`, 2: number of sub-units; must be ≥1.
- `UNIT_BITS`, `UP(CLOG2(NUM_UNITS))`: width of the unit select field.
- `NUM_WARPS`, 4: number of warps tracked.
- `NW_BITS`, `UP(CLOG2(NUM_WARPS))`: width of the warp id.
- `REQ_DATAW`, 64: request payload width.
- `RSP_DATAW`, 64: response payload width.
- `MAX_INFLIGHT`, 4: maximum outstanding requests per warp; must be ≥1.

Ports:
- `clk` in 1: clock; the block has one clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_unit` in UNIT_BITS: target sub-unit index.
- `req_wid` in NW_BITS: request warp id.
- `req_data` in REQ_DATAW: request payload.
- `unit_valid` out NUM_UNITS: per-unit request valid.
- `unit_ready` in NUM_UNITS: per-unit request ready.
- `unit_data` out REQ_DATAW: payload broadcast to all units, equal to `req_data`.
- `ursp_valid` in NUM_UNITS, `ursp_ready` out NUM_UNITS: per-unit response handshake.
- `ursp_wid` in NUM_UNITS*NW_BITS: per-unit response warp id; unit k occupies slice [k*NW_BITS +: NW_BITS].
- `ursp_data` in NUM_UNITS*RSP_DATAW: per-unit response payload; same slicing.
- `rsp_valid` out 1, `rsp_ready` in 1: merged commit handshake.
- `rsp_wid` out NW_BITS: merged response warp id.
- `rsp_data` out RSP_DATAW: merged response payload.
- `drain_req` in 1: when high, stall all new requests.
- `idle` out 1: no requests in flight and the output buffer is empty.
- `bad_unit` out 1: one-cycle pulse when a request with `req_unit ≥ NUM_UNITS` is consumed.

## Operation
- **Per-warp counters.** `cnt[w]` has width CLOG2(MAX_INFLIGHT+1).
  - It increments on a request handshake for warp w.
  - It decrements on an output handshake (`rsp_valid && rsp_ready`) for warp `rsp_wid`.
  - If both occur for the same warp in the same cycle, it is unchanged.
- **Stall condition.** `stall = drain_req || cnt[req_wid] == MAX_INFLIGHT`.
- **Request routing (combinational, zero latency).**
  - `unit_valid[k] = req_valid && !stall && req_unit == k`.
  - `req_ready = !stall && (req_unit < NUM_UNITS ? unit_ready[req_unit] : 1)`.
  - For an out-of-range unit, the request is consumed and dropped, `bad_unit` pulses in the next cycle (registered), and `cnt` does not increment.
- **Response merge.**
  - A round-robin arbiter selects among `ursp_valid`. The priority pointer starts at unit 0 after reset.
  - After a grant to unit g is accepted, the pointer moves to (g+1) mod NUM_UNITS.
  - `ursp_ready[g]` is high only for the granted unit, and only while the output buffer can accept.
- **Output buffer.** A 2-entry skid buffer holds {wid, data}. It sustains one response per cycle with registered `rsp_valid`/`rsp_data`.
- **Idle.** `idle = (all cnt == 0) && buffer empty`, registered.
- **Counter underflow.** A response handshake for a warp with `cnt == 0` is a protocol error: an assertion fires in simulation and the counter saturates at 0.
- **Full counter.** `cnt` never exceeds MAX_INFLIGHT, because the stall condition blocks any further increment.

## Timing
- **Reset values.**
  - `rsp_valid=0`, `bad_unit=0`, `idle=1`, all `cnt=0`, arbiter pointer = 0, buffer empty.
  - `unit_valid`, `ursp_ready` and `req_ready` follow their combinational equations from reset state.
  - Asserting reset mid-operation discards buffered responses and clears all counters in the next cycle. Sub-units are reset by their own relay.
- **Request path.** 0 cycles from `req_valid` to `unit_valid`. `req_ready` never depends on `unit_ready` of non-selected units.
- **Response path.** Responses reach `rsp_valid` 1 cycle after the handshake at the unit. Full throughput is 1/cycle with `rsp_ready` held high.
- **Backpressure.**
  - While `rsp_ready` is low, at most 2 responses are accepted, then all `ursp_ready` go low.
  - `rsp_data` remains stable while `rsp_valid && !rsp_ready`.
- **Drain.** `drain_req` takes effect combinationally in the same cycle. `idle` rises 1 cycle after the last output handshake drains the counters to zero.

## Test plan
- **Basic routing.** Reset, then NUM_UNITS=2, one request wid=1 unit=1 with unit 1 ready.
  - Required: `unit_valid=2'b10` in the same cycle, `cnt[1]=1`.
  - Unit 1 responds; `rsp_valid` rises 1 cycle later with wid=1. After the handshake, `cnt[1]=0` and `idle=1` the next cycle.
- **Round-robin fairness.** Both units hold `ursp_valid` for 6 cycles with `rsp_ready=1`.
  - Required: output order 0,1,0,1,0,1 and one response per cycle after the first.
- **Inflight limit.** MAX_INFLIGHT=4, with 5 back-to-back requests for wid=2 and no responses.
  - Required: 4 are accepted, `req_ready=0` on the 5th.
  - One output handshake for wid=2 makes `req_ready=1` in the following cycle.
- **Backpressure.** `rsp_ready=0` with unit 0 streaming responses.
  - Required: exactly 2 are accepted, then `ursp_ready=0`; `rsp_data` is stable.
  - Releasing `rsp_ready` drains the buffer in 2 cycles without loss or reordering.
- **Bad unit.** NUM_UNITS=3, request with unit=3.
  - Required: `req_ready=1`, no `unit_valid`, `bad_unit` pulses 1 cycle, `cnt` unchanged.
- **Drain and reset.**
  - `drain_req=1` with 2 responses outstanding: `req_ready=0`, and `idle` rises 1 cycle after the 2nd output handshake.
  - Reset asserted with the buffer full: the next cycle shows `rsp_valid=0`, `idle=1`, all counters 0.

Source files
------------

// File: rtl/alu_subunit_router.sv
// Request router and round-robin response merger for one ALU block.
// Steers requests to sub-units by unit index and merges responses into one buffered commit stream.
module alu_subunit_router #(
  parameter int NUM_UNITS    = 2,
  parameter int UNIT_BITS    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  parameter int NUM_WARPS    = 4,
  parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int REQ_DATAW    = 64,
  parameter int RSP_DATAW    = 64,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [UNIT_BITS-1:0]           req_unit,
  input  logic [NW_BITS-1:0]             req_wid,
  input  logic [REQ_DATAW-1:0]           req_data,
  output logic [NUM_UNITS-1:0]           unit_valid,
  input  logic [NUM_UNITS-1:0]           unit_ready,
  output logic [REQ_DATAW-1:0]           unit_data,
  input  logic [NUM_UNITS-1:0]           ursp_valid,
  output logic [NUM_UNITS-1:0]           ursp_ready,
  input  logic [NUM_UNITS*NW_BITS-1:0]   ursp_wid,
  input  logic [NUM_UNITS*RSP_DATAW-1:0] ursp_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [NW_BITS-1:0]             rsp_wid,
  output logic [RSP_DATAW-1:0]           rsp_data,
  input  logic                           drain_req,
  output logic                           idle,
  output logic                           bad_unit
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [UNIT_BITS:0] UNIT_LIMIT = (UNIT_BITS + 1)'(NUM_UNITS);
  localparam logic [CW-1:0]      CNT_MAX    = CW'(MAX_INFLIGHT);

  logic [CW-1:0]          cnt [NUM_WARPS];
  logic [CW-1:0]          req_cnt;
  logic                   in_range, sel_ready, stall, req_hs;
  logic [NUM_WARPS-1:0]   inc_w, dec_w;
  logic                   cnt_zero, rsp_cnt_nz, out_hs;

  logic [UNIT_BITS-1:0]   ptr, grant;
  logic                   found, can_accept, in_hs;
  logic [NW_BITS-1:0]     in_wid;
  logic [RSP_DATAW-1:0]   in_data;

  logic                   skid_valid;
  logic [NW_BITS-1:0]     skid_wid;
  logic [RSP_DATAW-1:0]   skid_data;

  assign unit_data  = req_data;
  assign out_hs     = rsp_valid && rsp_ready;
  assign can_accept = !skid_valid;

  // Request side: stall, routing and per-warp increment/decrement strobes.
  always_comb begin
    req_cnt   = '0;
    sel_ready = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++)
      if (NW_BITS'(w) == req_wid) req_cnt = cnt[w];
    for (int unsigned k = 0; k < NUM_UNITS; k++)
      if (UNIT_BITS'(k) == req_unit) sel_ready = unit_ready[k];
    in_range  = {1'b0, req_unit} < UNIT_LIMIT;
    stall     = drain_req || (req_cnt == CNT_MAX);
    req_ready = !stall && (in_range ? sel_ready : 1'b1);
    for (int unsigned k = 0; k < NUM_UNITS; k++)
      unit_valid[k] = req_valid && !stall && (UNIT_BITS'(k) == req_unit);
    req_hs = req_valid && req_ready;

    cnt_zero   = 1'b1;
    rsp_cnt_nz = 1'b0;
    inc_w      = '0;
    dec_w      = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (cnt[w] != '0) cnt_zero = 1'b0;
      if (NW_BITS'(w) == rsp_wid && cnt[w] != '0) rsp_cnt_nz = 1'b1;
      inc_w[w] = req_hs && in_range && (NW_BITS'(w) == req_wid);
      dec_w[w] = out_hs && (NW_BITS'(w) == rsp_wid);
    end
  end

  // Round-robin: first pass searches units at or above the pointer, second pass wraps around.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++)
      if (!found && ursp_valid[k] && UNIT_BITS'(k) >= ptr) begin
        found = 1'b1;
        grant = UNIT_BITS'(k);
      end
    for (int unsigned k = 0; k < NUM_UNITS; k++)
      if (!found && ursp_valid[k]) begin
        found = 1'b1;
        grant = UNIT_BITS'(k);
      end

    in_wid     = '0;
    in_data    = '0;
    ursp_ready = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++)
      if (UNIT_BITS'(k) == grant) begin
        in_wid        = ursp_wid[k*NW_BITS +: NW_BITS];
        in_data       = ursp_data[k*RSP_DATAW +: RSP_DATAW];
        ursp_ready[k] = found && can_accept;
      end
    in_hs = found && can_accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_wid    <= '0;
      rsp_data   <= '0;
      skid_valid <= 1'b0;
      skid_wid   <= '0;
      skid_data  <= '0;
      ptr        <= '0;
      bad_unit   <= 1'b0;
      idle       <= 1'b1;
      for (int unsigned w = 0; w < NUM_WARPS; w++) cnt[w] <= '0;
    end else begin
      bad_unit <= req_hs && !in_range;
      idle     <= cnt_zero && !rsp_valid && !skid_valid;

      if (in_hs)
        ptr <= (grant == UNIT_BITS'(NUM_UNITS - 1)) ? '0 : grant + 1'b1;

      // Skid entry only fills while the output register is stalled; it refills the output first.
      if (!rsp_valid || rsp_ready) begin
        if (skid_valid) begin
          rsp_valid  <= 1'b1;
          rsp_wid    <= skid_wid;
          rsp_data   <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          rsp_valid <= in_hs;
          if (in_hs) begin
            rsp_wid  <= in_wid;
            rsp_data <= in_data;
          end
        end
      end else if (in_hs) begin
        skid_valid <= 1'b1;
        skid_wid   <= in_wid;
        skid_data  <= in_data;
      end

      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (inc_w[w] && !dec_w[w])
          cnt[w] <= cnt[w] + 1'b1;
        else if (dec_w[w] && !inc_w[w] && cnt[w] != '0)
          cnt[w] <= cnt[w] - 1'b1;
      end
    end
  end

  // A commit for a warp with nothing in flight is a protocol error.
  underflow_chk: assert property (@(posedge clk) disable iff (reset) out_hs |-> rsp_cnt_nz);

endmodule

// File: tb/tb_alu_subunit_router.sv
// Directed bench for alu_subunit_router: a default instance (2 units) and a 3-unit instance
// for out-of-range unit handling.
module tb_alu_subunit_router;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [0:0]    req_unit;
  logic [1:0]    req_wid;
  logic [63:0]   req_data;
  logic [1:0]    unit_valid, unit_ready;
  logic [63:0]   unit_data;
  logic [1:0]    ursp_valid, ursp_ready;
  logic [3:0]    ursp_wid;
  logic [127:0]  ursp_data;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_wid;
  logic [63:0]   rsp_data;
  logic          drain_req, idle, bad_unit;

  logic          b_req_valid, b_req_ready;
  logic [1:0]    b_req_unit;
  logic [1:0]    b_req_wid;
  logic [2:0]    b_unit_valid, b_unit_ready;
  logic [63:0]   b_unit_data;
  logic [2:0]    b_ursp_ready;
  logic          b_rsp_valid;
  logic [1:0]    b_rsp_wid;
  logic [63:0]   b_rsp_data;
  logic          b_idle, b_bad_unit;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_subunit_router dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
    .req_wid(req_wid), .req_data(req_data),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_data(unit_data),
    .ursp_valid(ursp_valid), .ursp_ready(ursp_ready), .ursp_wid(ursp_wid),
    .ursp_data(ursp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid), .rsp_data(rsp_data),
    .drain_req(drain_req), .idle(idle), .bad_unit(bad_unit)
  );

  alu_subunit_router #(.NUM_UNITS(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_unit(b_req_unit),
    .req_wid(b_req_wid), .req_data(64'h0),
    .unit_valid(b_unit_valid), .unit_ready(b_unit_ready), .unit_data(b_unit_data),
    .ursp_valid(3'b000), .ursp_ready(b_ursp_ready), .ursp_wid(6'h0),
    .ursp_data(192'h0),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_wid(b_rsp_wid), .rsp_data(b_rsp_data),
    .drain_req(1'b0), .idle(b_idle), .bad_unit(b_bad_unit)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_unit = '0; req_wid = '0; req_data = '0;
    unit_ready = 2'b11; ursp_valid = '0; ursp_wid = '0; ursp_data = '0;
    rsp_ready = 1'b1; drain_req = 1'b0;
    b_req_valid = 1'b0; b_req_unit = '0; b_req_wid = '0; b_unit_ready = 3'b000;
    tick(); tick();

    // Reset state
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_bad_unit", bad_unit, 0);
    check("rst_idle", idle, 1);
    check("rst_req_ready", req_ready, 1);
    check("rst_unit_valid", unit_valid, 0);
    check("rst_ursp_ready", ursp_ready, 0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_cnt%0d", i), dut.cnt[i], 0);
    reset = 1'b0;

    // Basic routing
    req_valid = 1'b1; req_unit = 1'b1; req_wid = 2'd1; req_data = 64'h1234_5678_9abc_def0;
    #1;
    check("basic_unit_valid", unit_valid, 2'b10);
    check("basic_req_ready", req_ready, 1);
    check("basic_unit_data", unit_data, 64'h1234_5678_9abc_def0);
    tick();
    req_valid = 1'b0;
    check("basic_cnt1_inc", dut.cnt[1], 1);
    ursp_valid = 2'b10; ursp_wid = {2'd1, 2'd0}; ursp_data = {64'hD1, 64'h0};
    #1;
    check("basic_ursp_ready", ursp_ready, 2'b10);
    tick();
    ursp_valid = '0;
    check("basic_rsp_valid", rsp_valid, 1);
    check("basic_rsp_wid", rsp_wid, 1);
    check("basic_rsp_data", rsp_data, 64'hD1);
    check("basic_idle_busy", idle, 0);
    tick();
    check("basic_cnt1_dec", dut.cnt[1], 0);
    check("basic_rsp_empty", rsp_valid, 0);
    tick();
    check("basic_idle_back", idle, 1);

    // Round-robin: 3 requests per unit, then both units hold responses
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_unit = 1'(i % 2); req_wid = (i % 2 == 1) ? 2'd3 : 2'd0;
      tick();
    end
    req_valid = 1'b0;
    check("rr_cnt0", dut.cnt[0], 3);
    check("rr_cnt3", dut.cnt[3], 3);
    ursp_valid = 2'b11; ursp_wid = {2'd3, 2'd0}; ursp_data = {64'hB1, 64'hA0};
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr_valid%0d", k), rsp_valid, 1);
      check($sformatf("rr_data%0d", k), rsp_data, (k % 2 == 1) ? 64'hB1 : 64'hA0);
    end
    ursp_valid = '0;
    tick();
    check("rr_cnt0_done", dut.cnt[0], 0);
    check("rr_cnt3_done", dut.cnt[3], 0);
    tick();

    // Inflight limit on warp 2
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_unit = 1'b0; req_wid = 2'd2;
      #1;
      check($sformatf("lim_ready%0d", i), req_ready, (i < 4) ? 1 : 0);
      tick();
    end
    check("lim_cnt2_full", dut.cnt[2], 4);
    check("lim_unit_valid", unit_valid, 0);
    ursp_valid = 2'b01; ursp_wid = {2'd0, 2'd2}; ursp_data = {64'h0, 64'hC2};
    tick();
    ursp_valid = '0;
    check("lim_still_stalled", req_ready, 0);
    tick();
    check("lim_ready_after_commit", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("lim_cnt2_refill", dut.cnt[2], 4);

    // Backpressure: unit 0 streams while the commit side is blocked
    rsp_ready = 1'b0;
    ursp_valid = 2'b01; ursp_data = {64'h0, 64'hE0};
    #1;
    check("bp_ready0", ursp_ready, 2'b01);
    tick();
    ursp_data = {64'h0, 64'hE1};
    check("bp_ready1", ursp_ready, 2'b01);
    tick();
    ursp_data = {64'h0, 64'hE2};
    check("bp_ready_full", ursp_ready, 2'b00);
    check("bp_valid", rsp_valid, 1);
    check("bp_data_hold0", rsp_data, 64'hE0);
    tick();
    check("bp_data_hold1", rsp_data, 64'hE0);
    check("bp_ready_full2", ursp_ready, 2'b00);
    ursp_valid = '0; rsp_ready = 1'b1;
    tick();
    check("bp_drain1_valid", rsp_valid, 1);
    check("bp_drain1_data", rsp_data, 64'hE1);
    tick();
    check("bp_drain_empty", rsp_valid, 0);
    check("bp_cnt2", dut.cnt[2], 2);

    // Drain with two responses outstanding
    drain_req = 1'b1; req_valid = 1'b1; req_unit = 1'b0; req_wid = 2'd0;
    #1;
    check("drain_req_ready", req_ready, 0);
    check("drain_unit_valid", unit_valid, 0);
    ursp_valid = 2'b01; ursp_data = {64'h0, 64'hF0};
    tick();
    ursp_data = {64'h0, 64'hF1};
    tick();
    ursp_valid = '0;
    check("drain_second_data", rsp_data, 64'hF1);
    tick();
    check("drain_cnt2_zero", dut.cnt[2], 0);
    check("drain_idle_not_yet", idle, 0);
    tick();
    check("drain_idle", idle, 1);
    drain_req = 1'b0; req_valid = 1'b0;

    // Reset with the buffer full
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_unit = 1'b1; req_wid = 2'd1;
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    ursp_valid = 2'b10; ursp_wid = {2'd1, 2'd0}; ursp_data = {64'hAA, 64'h0};
    tick(); tick();
    check("rstfull_ursp_ready", ursp_ready, 2'b00);
    check("rstfull_rsp_valid", rsp_valid, 1);
    ursp_valid = '0;
    reset = 1'b1;
    tick();
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_idle", idle, 1);
    for (int i = 0; i < 4; i++) check($sformatf("rstmid_cnt%0d", i), dut.cnt[i], 0);
    reset = 1'b0; rsp_ready = 1'b1;
    tick();

    // Out-of-range unit on the 3-unit instance
    b_req_valid = 1'b1; b_req_unit = 2'd3; b_req_wid = 2'd0;
    #1;
    check("bad_req_ready", b_req_ready, 1);
    check("bad_unit_valid", b_unit_valid, 0);
    check("bad_pulse_before", b_bad_unit, 0);
    tick();
    b_req_valid = 1'b0;
    check("bad_pulse", b_bad_unit, 1);
    check("bad_cnt0", dut3.cnt[0], 0);
    tick();
    check("bad_pulse_end", b_bad_unit, 0);
    b_req_valid = 1'b1; b_req_unit = 2'd2;
    #1;
    check("bad_inrange_unit_valid", b_unit_valid, 3'b100);
    check("bad_inrange_not_ready", b_req_ready, 0);
    b_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
